// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB3 requester; the optional ACCESS-phase timeout is enabled by APB_TIMEOUT_EN
module apb_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t r_state;
  logic   w_accept;

  assign cmd_ready = (r_state == ST_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_timeout;

  // Counter holds the number of wait cycles already seen, so the limit fires in the last allowed cycle.
  assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= ST_IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      r_wait_cnt <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            pwrite  <= cmd_write;
            paddr   <= cmd_addr;
            pwdata  <= cmd_wdata;
            psel    <= 1'b1;
            penable <= 1'b0;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable <= 1'b1;
          r_state <= ST_ACCESS;
`ifdef APB_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        ST_ACCESS: begin
          if (pready) begin
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            r_state   <= ST_RESP;
          end
`ifdef APB_TIMEOUT_EN
          else if (w_timeout) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            r_state   <= ST_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed testbench for apb_master
module tb_apb_master;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        pready, pslverr;
  logic [31:0] prdata;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  task automatic test_reset;
    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    @(negedge pclk); @(negedge pclk);
    checks++; if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {psel, penable, pwrite, rsp_valid, rsp_err}); end
    checks++; if ({paddr, pwdata, rsp_rdata} !== 96'h0)
      begin errors++; $display("FAIL reset_data: got %h expected 0", {paddr, pwdata, rsp_rdata}); end
    checks++; if (cmd_ready !== 1'b1)
      begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    presetn = 1'b1;
    @(negedge pclk);
    checks++; if ({cmd_ready, psel} !== 2'b10)
      begin errors++; $display("FAIL post_reset: got %b expected 10", {cmd_ready, psel}); end
  endtask

  task automatic test_write_zero_wait;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4; cmd_wdata = 32'h12345678;
    pready = 1'b1; prdata = 32'hAAAA5555; pslverr = 1'b0; rsp_ready = 1'b0;
    @(negedge pclk);
    checks++; if ({psel, penable, pwrite, cmd_ready} !== 4'b1010)
      begin errors++; $display("FAIL wr_setup: got %b expected 1010", {psel, penable, pwrite, cmd_ready}); end
    checks++; if (paddr !== 32'h4 || pwdata !== 32'h12345678)
      begin errors++; $display("FAIL wr_addr_data: got %h/%h expected 00000004/12345678", paddr, pwdata); end
    cmd_valid = 1'b0;
    @(negedge pclk);
    checks++; if ({psel, penable, rsp_valid} !== 3'b110)
      begin errors++; $display("FAIL wr_access: got %b expected 110", {psel, penable, rsp_valid}); end
    @(negedge pclk);
    checks++; if ({psel, penable, rsp_valid, rsp_err} !== 4'b0010)
      begin errors++; $display("FAIL wr_resp: got %b expected 0010", {psel, penable, rsp_valid, rsp_err}); end
    checks++; if (rsp_rdata !== 32'h0)
      begin errors++; $display("FAIL wr_rdata: got %h expected 00000000", rsp_rdata); end
    checks++; if (pwdata !== 32'h12345678 || paddr !== 32'h4)
      begin errors++; $display("FAIL wr_hold: got %h/%h expected 00000004/12345678", paddr, pwdata); end
    rsp_ready = 1'b1;
    @(negedge pclk);
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01)
      begin errors++; $display("FAIL wr_consume: got %b expected 01", {rsp_valid, cmd_ready}); end
    rsp_ready = 1'b0; pready = 1'b0;
  endtask

  task automatic test_read_wait;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8; cmd_wdata = 32'h0;
    pready = 1'b0; prdata = 32'h11111111;
    @(negedge pclk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      checks++; if ({psel, penable, pwrite, rsp_valid} !== 4'b1100 || paddr !== 32'h8)
        begin errors++; $display("FAIL rd_wait_%0d: got %b addr %h expected 1100 addr 00000008", i, {psel, penable, pwrite, rsp_valid}, paddr); end
      if (i == 2) begin pready = 1'b1; prdata = 32'hFACE5678; end
    end
    @(negedge pclk);
    pready = 1'b0; prdata = 32'h0;
    checks++; if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'hFACE5678)
      begin errors++; $display("FAIL rd_resp: got %b data %h expected 10 data face5678", {rsp_valid, rsp_err}, rsp_rdata); end
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_error;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hC;
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hDEADBEEF;
    @(negedge pclk);
    cmd_valid = 1'b0;
    checks++; if (paddr !== 32'hC)
      begin errors++; $display("FAIL err_addr: got %h expected 0000000c", paddr); end
    @(negedge pclk);
    @(negedge pclk);
    checks++; if ({rsp_valid, rsp_err} !== 2'b11 || rsp_rdata !== 32'hDEADBEEF)
      begin errors++; $display("FAIL err_resp: got %b data %h expected 11 data deadbeef", {rsp_valid, rsp_err}, rsp_rdata); end
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hA5A5A5A5;
    pready = 1'b1; prdata = 32'h0BADF00D; rsp_ready = 1'b0;
    @(negedge pclk);
    cmd_write = 1'b0; cmd_addr = 32'h14; cmd_wdata = 32'h0;
    @(negedge pclk);
    checks++; if (cmd_ready !== 1'b0)
      begin errors++; $display("FAIL bp_access_ready: got %b expected 0", cmd_ready); end
    @(negedge pclk);
    for (int i = 0; i < 3; i++) begin
      checks++; if ({rsp_valid, rsp_err, cmd_ready, psel} !== 4'b1000 || rsp_rdata !== 32'h0)
        begin errors++; $display("FAIL bp_hold_%0d: got %b data %h expected 1000 data 00000000", i, {rsp_valid, rsp_err, cmd_ready, psel}, rsp_rdata); end
      @(negedge pclk);
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, cmd_ready, psel} !== 3'b010 || paddr !== 32'h10)
      begin errors++; $display("FAIL bp_release: got %b addr %h expected 010 addr 00000010", {rsp_valid, cmd_ready, psel}, paddr); end
    @(negedge pclk);
    cmd_valid = 1'b0;
    checks++; if ({psel, penable, pwrite} !== 3'b100 || paddr !== 32'h14)
      begin errors++; $display("FAIL bp_second_accept: got %b addr %h expected 100 addr 00000014", {psel, penable, pwrite}, paddr); end
    @(negedge pclk);
    @(negedge pclk);
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BADF00D)
      begin errors++; $display("FAIL bp_second_resp: got %b data %h expected 1 data 0badf00d", rsp_valid, rsp_rdata); end
    rsp_ready = 1'b1; pready = 1'b0;
    @(negedge pclk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_access;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; pready = 1'b0;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    checks++; if ({psel, penable} !== 2'b11)
      begin errors++; $display("FAIL rst_pre_access: got %b expected 11", {psel, penable}); end
    presetn = 1'b0;
    #1;
    checks++; if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0001 || paddr !== 32'h0)
      begin errors++; $display("FAIL rst_async: got %b addr %h expected 0001 addr 00000000", {psel, penable, rsp_valid, cmd_ready}, paddr); end
    @(negedge pclk);
    presetn = 1'b1; pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      checks++; if ({psel, rsp_valid, cmd_ready} !== 3'b001)
        begin errors++; $display("FAIL rst_no_stale_%0d: got %b expected 001", i, {psel, rsp_valid, cmd_ready}); end
    end
    pready = 1'b0;
  endtask

  task automatic test_timeout;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30; pready = 1'b0; prdata = 32'h55555555;
    @(negedge pclk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge pclk);
      checks++; if ({psel, penable, rsp_valid} !== 3'b110)
        begin errors++; $display("FAIL to_wait_%0d: got %b expected 110", i, {psel, penable, rsp_valid}); end
    end
`ifdef APB_TIMEOUT_EN
    @(negedge pclk);
    checks++; if ({psel, penable, rsp_valid, rsp_err} !== 4'b0011 || rsp_rdata !== 32'h0)
      begin errors++; $display("FAIL to_abort: got %b data %h expected 0011 data 00000000", {psel, penable, rsp_valid, rsp_err}, rsp_rdata); end
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 32'h34;
    @(negedge pclk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge pclk);
      if (i == 15) begin pready = 1'b1; prdata = 32'h12121212; end
    end
    @(negedge pclk);
    pready = 1'b0;
    checks++; if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h12121212)
      begin errors++; $display("FAIL to_pready_wins: got %b data %h expected 10 data 12121212", {rsp_valid, rsp_err}, rsp_rdata); end
`else
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      checks++; if ({psel, penable, rsp_valid} !== 3'b110)
        begin errors++; $display("FAIL no_to_wait_%0d: got %b expected 110", i, {psel, penable, rsp_valid}); end
      if (i == 3) begin pready = 1'b1; prdata = 32'h0; end
    end
    @(negedge pclk);
    pready = 1'b0;
    checks++; if ({rsp_valid, rsp_err} !== 2'b10)
      begin errors++; $display("FAIL no_to_finish: got %b expected 10", {rsp_valid, rsp_err}); end
`endif
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_error();
    test_back_to_back();
    test_reset_mid_access();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
